// File: rtl/f32_mult_arb.sv
// f32_mult_arb: round-robin arbiter sharing one multi-cycle f32_mult between
// N_REQ requesters, returning each product (or a timeout error) to its issuer.
module f32_mult_arb #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_p,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mul_start,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic                 mul_done,
  input  logic [31:0]          mul_p
);
  localparam int unsigned NR   = N_REQ;
  localparam int          IW   = $clog2(N_REQ);
  localparam int          CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] ptr, gnt, gnt_idx, cand;
  logic          gnt_any, done_ok, tmo;
  logic [CW-1:0] cnt;

  // First pending requester scanning upward from ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      cand = IW'((32'(ptr) + k) % NR);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // A done pulse coinciding with mul_start belongs to nothing we issued.
  assign done_ok = (state == WAIT) && mul_done && !mul_start;
  assign tmo     = (state == WAIT) && (TIMEOUT != 0) && (cnt == CW'(TLIM));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (gnt_any) state_nx = WAIT;
      WAIT:    if (done_ok || tmo) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      gnt       <= '0;
      cnt       <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_p     <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      mul_start <= 1'b0;
      if (state == IDLE && gnt_any) begin
        mul_a              <= req_a[gnt_idx*32 +: 32];
        mul_b              <= req_b[gnt_idx*32 +: 32];
        gnt                <= gnt_idx;
        req_ready[gnt_idx] <= 1'b1;
        mul_start          <= 1'b1;
        cnt                <= '0;
        ptr                <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state == WAIT) begin
        cnt <= cnt + 1'b1;
        if (done_ok) begin
          rsp_p          <= mul_p;
          rsp_err        <= 1'b0;
          rsp_valid[gnt] <= 1'b1;
        end else if (tmo) begin
          rsp_p          <= '0;
          rsp_err        <= 1'b1;
          rsp_valid[gnt] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_f32_mult_arb.sv
// Randomized bench for f32_mult_arb with a latency-configurable multiplier
// model and a transaction-level round-robin/response reference.
module tb_f32_mult_arb;
  localparam int N   = 4;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_a, req_b;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [31:0]     rsp_p, mul_a, mul_b, mul_p;
  logic            rsp_err, busy, mul_start, mul_done;

  always #5 clk = ~clk;

  f32_mult_arb #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_p(rsp_p), .rsp_err(rsp_err),
    .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_p(mul_p)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Multiplier behaviour: known IEEE products, otherwise an operand-dependent tag.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40200000 && b == 32'h40E00000) return 32'h418C0000;
    if (a == 32'h40400000 && b == 32'hC0000000) return 32'hC0C00000;
    if (a == 32'h3F800000 && b == 32'h3F800000) return 32'h3F800000;
    return {a[15:0] ^ b[31:16], a[31:16] + b[15:0]};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (((v >> j) & N'(1)) != '0) return j;
    end
    return -1;
  endfunction

  // multiplier model
  int          lat = 2;
  bit          hang = 0, inj_start = 0, inj_now = 0;
  int          m_cnt;
  bit          mbusy;
  logic [31:0] ma, mb;

  initial begin
    mul_done = 1'b0; mul_p = '0; mbusy = 0; m_cnt = 0; ma = '0; mb = '0;
    forever begin
      @(posedge clk); #1;
      mul_done = 1'b0; mul_p = '0;
      if (!rst_n) mbusy = 0;
      else if (mul_start) begin
        mbusy = 1; m_cnt = lat; ma = mul_a; mb = mul_b;
        if (inj_start) begin mul_done = 1'b1; mul_p = 32'hDEADBEEF; end
      end else if (mbusy && !hang) begin
        m_cnt--;
        if (m_cnt == 0) begin mul_done = 1'b1; mul_p = ref_mul(ma, mb); mbusy = 0; end
      end
      if (inj_now) begin mul_done = 1'b1; mul_p = 32'hBAADF00D; inj_now = 0; end
    end
  end

  // reference model / monitor
  logic [31:0] opa [N];
  logic [31:0] opb [N];
  logic [N-1:0] last_valid, exp_rdy;
  int  cyc = 0, ref_ptr = 0, m_g = 0, g = 0, start_cyc = 0;
  bit  m_inflight = 0, rsp_exp = 0, exp_err = 0;
  logic [31:0] exp_p;
  int  rsp_cnt = 0, last_rsp_idx = -1, last_rsp_cyc = 0;
  logic [31:0] last_rsp_p;
  bit  last_rsp_err;
  int  grant_log[$], start_log[$], rsp_idx_log[$];
  logic [31:0] rsp_p_log[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_inflight = 0; rsp_exp = 0; ref_ptr = 0; last_valid = '0;
    end else begin
      cyc++;
      if (rsp_exp) begin
        chk("rsp_idx", rsp_valid, N'(1) << m_g);
        chk("rsp_p", rsp_p, exp_p);
        chk("rsp_err", rsp_err, exp_err);
        rsp_cnt++; last_rsp_idx = m_g; last_rsp_p = rsp_p; last_rsp_err = rsp_err;
        last_rsp_cyc = cyc; rsp_idx_log.push_back(m_g); rsp_p_log.push_back(rsp_p);
        rsp_exp = 0; m_inflight = 0;
      end else if (rsp_valid != '0) chk("rsp_spurious", rsp_valid, 0);
      if (req_ready != '0 || mul_start) begin
        g = rr_pick(last_valid, ref_ptr);
        exp_rdy = (g < 0) ? '0 : N'(1) << g;
        chk("grant_overlap", m_inflight, 0);
        chk("grant", req_ready, exp_rdy);
        chk("mul_start", mul_start, 1);
        if (g >= 0) begin
          chk("mul_a", mul_a, opa[g]);
          chk("mul_b", mul_b, opb[g]);
          m_inflight = 1; m_g = g; start_cyc = cyc;
          exp_p = ref_mul(opa[g], opb[g]); exp_err = 0;
          ref_ptr = (g + 1) % N;
          grant_log.push_back(g); start_log.push_back(cyc);
        end
      end else if (m_inflight && !rsp_exp) begin
        if (mul_done) rsp_exp = 1;
        else if (cyc == start_cyc + TMO - 1) begin
          rsp_exp = 1; exp_p = '0; exp_err = 1;
        end
      end
      last_valid = req_valid;
    end
  end

  task automatic drive_one(input int i, input logic [31:0] a, input logic [31:0] b, input bit keep);
    int w;
    opa[i] = a; opb[i] = b;
    req_a[i*32 +: 32] = a; req_b[i*32 +: 32] = b;
    req_valid[i] = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!req_ready[i] && w < 400);
    if (!req_ready[i]) chk("ready_wait", req_ready[i], 1);
    @(posedge clk); #1;
    if (!keep) req_valid[i] = 1'b0;
  endtask

  task automatic drive(input int i, input int nops, input int maxgap);
    for (int n = 0; n < nops; n++) begin
      int gap;
      gap = $urandom_range(0, maxgap);
      drive_one(i, $urandom, $urandom, (gap == 0) && (n + 1 < nops));
      if (gap > 0) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run_mask(input logic [3:0] m, input int nops, input int maxgap);
    fork
      if (m[0]) drive(0, nops, maxgap);
      if (m[1]) drive(1, nops, maxgap);
      if (m[2]) drive(2, nops, maxgap);
      if (m[3]) drive(3, nops, maxgap);
    join
  endtask

  task automatic wait_rsp(input int target);
    int w;
    w = 0;
    while (rsp_cnt < target && w < 1000) begin @(negedge clk); w++; end
    if (rsp_cnt < target) chk("rsp_wait", rsp_cnt, target);
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int b, gl, sl, k0, raise_cyc;
    logic [3:0] m;
    int nops;
    req_valid = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    repeat (2) @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_rsp_p", rsp_p, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single request 2.5 * 7.0
    lat = 3;
    raise_cyc = cyc;
    drive_one(0, 32'h40200000, 32'h40E00000, 0);
    wait_rsp(1);
    chk("p1_idx", last_rsp_idx, 0);
    chk("p1_p", last_rsp_p, 32'h418C0000);
    chk("p1_err", last_rsp_err, 0);
    chk("p1_grants", grant_log.size(), 1);
    chk("p1_start_lat", start_cyc - raise_cyc, 2);
    chk("p1_rsp_lat", last_rsp_cyc - start_cyc, lat + 1);

    // two simultaneous requesters with ptr back at 0
    reset_dut();
    @(posedge clk); #1;
    gl = grant_log.size(); k0 = rsp_idx_log.size(); b = rsp_cnt;
    fork
      drive_one(1, 32'h40400000, 32'hC0000000, 0);
      drive_one(3, 32'h3F800000, 32'h3F800000, 0);
    join
    wait_rsp(b + 2);
    chk("p2_first", grant_log[gl], 1);
    chk("p2_second", grant_log[gl+1], 3);
    chk("p2_rsp0_idx", rsp_idx_log[k0], 1);
    chk("p2_rsp0_p", rsp_p_log[k0], 32'hC0C00000);
    chk("p2_rsp1_idx", rsp_idx_log[k0+1], 3);
    chk("p2_rsp1_p", rsp_p_log[k0+1], 32'h3F800000);

    // all requesters continuously valid for 8 operations
    lat = 2; gl = grant_log.size(); sl = start_log.size(); b = rsp_cnt;
    run_mask(4'hF, 2, 0);
    wait_rsp(b + 8);
    repeat (10) @(posedge clk); #1;
    chk("p3_rsp_count", rsp_cnt - b, 8);
    for (int k = 0; k < 8; k++) chk("p3_rr_order", grant_log[gl+k], k % 4);
    for (int k = 0; k < 7; k++) chk("p3_issue_gap", start_log[sl+k+1] - start_log[sl+k], lat + 3);

    // randomized traffic
    for (int it = 0; it < 20; it++) begin
      lat = $urandom_range(1, 6);
      inj_start = ($urandom_range(0, 3) == 0);
      m = 4'($urandom_range(1, 15));
      nops = $urandom_range(1, 3);
      b = rsp_cnt;
      run_mask(m, nops, 2);
      wait_rsp(b + $countones(m) * nops);
      chk("rand_rsp_count", rsp_cnt - b, $countones(m) * nops);
    end
    inj_start = 0;

    // multiplier that never finishes
    hang = 1; b = rsp_cnt;
    drive_one(2, 32'h40400000, 32'h40400000, 0);
    wait_rsp(b + 1);
    chk("tmo_idx", last_rsp_idx, 2);
    chk("tmo_err", last_rsp_err, 1);
    chk("tmo_p", last_rsp_p, 0);
    chk("tmo_lat", last_rsp_cyc - start_cyc, TMO);
    hang = 0;
    repeat (3) @(posedge clk); #1;
    inj_now = 1;
    repeat (8) @(posedge clk); #1;
    chk("tmo_late_done", rsp_cnt, b + 1);

    // done pulses during mul_start and while idle
    lat = 4; inj_start = 1; b = rsp_cnt;
    drive_one(1, 32'h3F800000, 32'h3F800000, 0);
    wait_rsp(b + 1);
    inj_start = 0;
    chk("stray_idx", last_rsp_idx, 1);
    chk("stray_p", last_rsp_p, 32'h3F800000);
    chk("stray_err", last_rsp_err, 0);
    chk("stray_lat", last_rsp_cyc - start_cyc, lat + 1);
    inj_now = 1;
    repeat (6) @(posedge clk); #1;
    chk("idle_done", rsp_cnt, b + 1);
    chk("idle_busy", busy, 0);

    // asynchronous reset while waiting on the multiplier
    hang = 1;
    drive_one(1, 32'h12345678, 32'h9ABCDEF0, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_mul_start", mul_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mul_a", mul_a, 0);
    chk("arst_mul_b", mul_b, 0);
    chk("arst_rsp_p", rsp_p, 0);
    chk("arst_rsp_err", rsp_err, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    hang = 0; b = rsp_cnt; gl = grant_log.size();
    @(posedge clk); #1;
    repeat (4) @(posedge clk); #1;
    chk("arst_no_rsp", rsp_cnt, b);
    run_mask(4'hF, 1, 0);
    wait_rsp(b + 4);
    chk("arst_first_grant", grant_log[gl], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/f32_mult_arb.md
# f32_mult_arb

Round-robin arbiter that shares a single multi-cycle `f32_mult` single-precision multiplier between `N_REQ` requesters. The arbiter accepts operand pairs from requesters with a valid/ready handshake and drives the multiplier's start/done interface. It returns each product to the requester that issued it with a one-cycle response pulse. It sits between the datapath clients and the `f32_mult` instance, and it is the only block that drives that instance's `start`, `a` and `b` inputs.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 64: maximum number of cycles to wait for `mul_done`; 0 disables the timeout.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous reset, active-low.
- `req_valid`  in  N_REQ: requester i has an operand pair pending; held high until `req_ready[i]` is seen.
- `req_a`  in  32*N_REQ: operand A of requester i in bits [32i+31:32i], IEEE-754 single precision.
- `req_b`  in  32*N_REQ: operand B, with the same packing as `req_a`.
- `req_ready`  out  N_REQ: one-cycle pulse; the operands of requester i were accepted.
- `rsp_valid`  out  N_REQ: one-cycle pulse; `rsp_p`/`rsp_err` belong to requester i.
- `rsp_p`  out  32: product; valid only while some `rsp_valid` bit is high.
- `rsp_err`  out  1: the response was produced by a timeout; valid with `rsp_valid`.
- `busy`  out  1: an operation is in flight (state ≠ IDLE).
- `mul_start`  out  1: one-cycle start pulse to the multiplier.
- `mul_a`, `mul_b`  out  32: multiplier operands; held stable from `mul_start` until the operation completes.
- `mul_done`  in  1: multiplier completion pulse.
- `mul_p`  in  32: multiplier product; valid while `mul_done` is high.

## Operation
- States:
  - IDLE: no operation in flight; the arbiter samples requests.
  - WAIT: the multiplier is running.
  - RESP: the result is being returned to the requester.
- IDLE, when any `req_valid` bit is high:
  - Grant g = first set index scanning upward from pointer `ptr`, wrapping modulo N_REQ.
  - Latch `req_a[g]` and `req_b[g]` into `mul_a`/`mul_b`; latch g.
  - Next cycle: `req_ready[g]`=1 and `mul_start`=1; state goes to WAIT.
  - `ptr` ← (g+1) mod N_REQ.
- IDLE with no request: all pulse outputs stay at 0.
- WAIT:
  - The timeout counter increments every cycle.
  - On `mul_done`=1: latch `mul_p` into `rsp_p`, set `rsp_err`=0, go to RESP.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT without `mul_done`: `rsp_p`=0, `rsp_err`=1, go to RESP.
  - `mul_done` asserted in the cycle `mul_start` is high is ignored, because the multiplier latency is ≥1.
- RESP: `rsp_valid[g]`=1 for exactly one cycle, then IDLE.
- `mul_done` received in IDLE or RESP is ignored (a stray or late pulse after a timeout).
- `req_valid` of requesters that are not granted is untouched; they remain pending and are never dropped.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0; no requester waits more than N_REQ-1 operations.
- Reset (asynchronous, at any time including mid-operation):
  - State goes to IDLE and `ptr`=0.
  - All outputs go to 0.
  - The in-flight result is discarded and no response is issued for it.

## Timing
- Request sampled in IDLE at edge t:
  - `req_ready[g]` and `mul_start` are high in cycle t+1.
  - `mul_a`/`mul_b` are valid from t+1.
- `mul_done` high in cycle d: `rsp_valid[g]` and `rsp_p` are high/valid in cycle d+1 (RESP).
- Back-to-back issue: IDLE in cycle d+2, so the earliest next `mul_start` is in d+3.
- Throughput: one operation per (multiplier latency + 3) cycles.
- Requester i must keep `req_a`/`req_b` stable while `req_valid[i]`=1.
- Requester i may re-raise `req_valid[i]` for a new request from the cycle after `req_ready[i]`. The new request is not granted before the pending response is delivered.
- All outputs are registered and carry no combinational path from inputs.

## Test plan
- Reset, then requester 0 sends a=0x40200000 (2.5), b=0x40E00000 (7.0):
  - `req_ready[0]` and `mul_start` pulse once.
  - `rsp_valid[0]` pulses with `rsp_p`=0x418C0000 (17.5) and `rsp_err`=0.
- Requesters 1 and 3 raise valid in the same cycle, with `ptr`=0:
  - Requester 1 is served first: 0x40400000×0xC0000000 → 0xC0C00000.
  - Requester 3 is served next: 0x3F800000×0x3F800000 → 0x3F800000.
  - `rsp_valid` is never asserted to the wrong index.
- All four requesters are held valid for 8 operations: grant order is 0,1,2,3,0,1,2,3 and there are exactly 8 `rsp_valid` pulses.
- Multiplier model that never asserts `mul_done`, with TIMEOUT=64:
  - `rsp_valid[g]` occurs exactly 64 cycles after `mul_start`, with `rsp_err`=1 and `rsp_p`=0.
  - A `mul_done` injected later produces no response.
- `rst_n` pulsed low in WAIT:
  - All outputs are 0 immediately, with no `rsp_valid` for the aborted operation.
  - The next request is granted from index 0.
- A `mul_done` pulse is injected while `mul_start` is high and while in IDLE: both pulses are ignored, and `rsp_valid` follows only the genuine `mul_done`.
